// File: rtl/weight_col_sequencer_16_pkg.sv
// Shared types and constants for the weight column sequencer.
// Optional build macro: ZERO_COL_SKIP_EN (skip all-zero columns).
package wave_seq_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int VEC_LENGTH    = 16;
  localparam int NUM_COLS      = DATA_WIDTH - 1;
  localparam int COL_IDX_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    DRAIN
  } seq_state_t;

  typedef logic [DATA_WIDTH-2:0] mag_t;

  // -128 has no positive twin; saturate to 127
  function automatic mag_t to_mag(
    input logic [DATA_WIDTH-1:0] w
  );
    logic [DATA_WIDTH-1:0] n;
    n = w[DATA_WIDTH-1] ? -w : w;
    return n[DATA_WIDTH-1] ? '1 : n[DATA_WIDTH-2:0];
  endfunction

endpackage

// File: rtl/weight_col_sequencer_16_if.sv
// Weight-in handshake plus column-beat outputs toward the MAC.
// slave: sequencer side; master: feeder/consumer side.
interface weight_col_sequencer_16_if;
  import wave_seq_pkg::*;

  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w_in;
  logic                     w_valid;
  logic                     w_ready;
  logic                     stall;
  logic [VEC_LENGTH-1:0]    sign;
  logic [VEC_LENGTH-1:0]    w_bit;
  logic [COL_IDX_WIDTH-1:0] column_idx;
  logic                     mac_en;
  logic                     load_accum;
  logic                     last_col;
  logic                     busy;

  modport slave (
    input  w_in, w_valid, stall,
    output w_ready, sign, w_bit, column_idx,
    output mac_en, load_accum, last_col, busy
  );

  modport master (
    output w_in, w_valid, stall,
    input  w_ready, sign, w_bit, column_idx,
    input  mac_en, load_accum, last_col, busy
  );

endinterface

// File: rtl/weight_col_sequencer_16_col_priority_pick.sv
// Picks the highest pending column, its clear mask, and last flag.
// pend_i: pending columns; idx_o/clear_o/last_o: pick results.
module col_priority_pick
  import wave_seq_pkg::*;
(
  input  logic [NUM_COLS-1:0]      pend_i,
  output logic [COL_IDX_WIDTH-1:0] idx_o,
  output logic [NUM_COLS-1:0]      clear_o,
  output logic                     last_o
);

  always_comb begin
    idx_o   = '0;
    clear_o = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (pend_i[i]) idx_o = COL_IDX_WIDTH'(i);
    end
    clear_o[idx_o] = 1'b1;
    last_o = (pend_i != '0) &&
      ((pend_i & (pend_i - NUM_COLS'(1))) == '0);
  end

endmodule

// File: rtl/weight_col_sequencer_16.sv
// Bit-serial weight feeder: sign-magnitude, MSB-first column beats.
// Ports: clk, reset (sync, active-high), bus (slave modport).
// Macro ZERO_COL_SKIP_EN: skip all-zero columns (else 7 beats).
module weight_col_sequencer_16
  import wave_seq_pkg::*;
(
  input logic                      clk,
  input logic                      reset,
  weight_col_sequencer_16_if.slave bus
);

  seq_state_t state_q, state_d;
  logic [NUM_COLS-1:0]      pend_q, pend_d;
  mag_t                     mag_q [VEC_LENGTH];
  mag_t                     mag_d [VEC_LENGTH];
  logic [VEC_LENGTH-1:0]    sign_q, sign_d;
  logic [VEC_LENGTH-1:0]    wbit_q, wbit_d;
  logic [COL_IDX_WIDTH-1:0] col_q, col_d;
  logic en_q, en_d, last_q, last_d;
  logic load_q, load_d, first_q, first_d;

  logic                     ready;
  logic                     accept;
  mag_t                     new_mag [VEC_LENGTH];
  logic [VEC_LENGTH-1:0]    new_sign;
  logic [NUM_COLS-1:0]      new_pend;
  logic [NUM_COLS-1:0]      src_pend;
  logic [NUM_COLS-1:0]      clr;
  logic [COL_IDX_WIDTH-1:0] pick_idx;
  logic                     pick_last;
  logic [VEC_LENGTH-1:0]    beat_wbit;

  always_comb begin
    for (int j = 0; j < VEC_LENGTH; j++) begin
      new_sign[j] = bus.w_in[j][DATA_WIDTH-1];
      new_mag[j]  = to_mag(bus.w_in[j]);
    end
  end

`ifdef ZERO_COL_SKIP_EN
  logic [NUM_COLS-1:0] occ;

  always_comb begin
    occ = '0;
    for (int j = 0; j < VEC_LENGTH; j++)
      occ = occ | new_mag[j];
  end

  // empty vector still yields one beat at column 0
  assign new_pend = (occ == '0) ? NUM_COLS'(1) : occ;
`else
  assign new_pend = '1;
`endif

  // EMIT accepts only on its final beat: no bubble
  assign ready = !reset && !bus.stall &&
    (state_q != EMIT || last_q);
  assign accept   = bus.w_valid && ready;
  assign src_pend = accept ? new_pend : pend_q;

  col_priority_pick u_pick (
    .pend_i  (src_pend),
    .idx_o   (pick_idx),
    .clear_o (clr),
    .last_o  (pick_last)
  );

  always_comb begin
    for (int j = 0; j < VEC_LENGTH; j++)
      beat_wbit[j] = accept ? new_mag[j][pick_idx]
                            : mag_q[j][pick_idx];
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    mag_d   = mag_q;
    sign_d  = sign_q;
    wbit_d  = wbit_q;
    col_d   = col_q;
    en_d    = en_q;
    last_d  = last_q;
    load_d  = load_q;
    first_d = first_q;
    if (!bus.stall) begin
      load_d  = first_q;
      first_d = 1'b0;
      en_d    = 1'b0;
      last_d  = 1'b0;
      unique case (1'b1)
        accept: begin
          state_d = EMIT;
          mag_d   = new_mag;
          sign_d  = new_sign;
          first_d = 1'b1;
          col_d   = pick_idx;
          wbit_d  = beat_wbit;
          pend_d  = src_pend & ~clr;
          en_d    = 1'b1;
          last_d  = pick_last;
        end
        (state_q == EMIT && !last_q): begin
          col_d  = pick_idx;
          wbit_d = beat_wbit;
          pend_d = src_pend & ~clr;
          en_d   = 1'b1;
          last_d = pick_last;
        end
        (state_q == EMIT && last_q && !accept): begin
          // flush the MAC's psum register
          state_d = DRAIN;
          wbit_d  = '0;
          col_d   = '0;
          pend_d  = '0;
          en_d    = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      sign_q  <= '0;
      wbit_q  <= '0;
      col_q   <= '0;
      en_q    <= 1'b0;
      last_q  <= 1'b0;
      load_q  <= 1'b0;
      first_q <= 1'b0;
      for (int j = 0; j < VEC_LENGTH; j++)
        mag_q[j] <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      sign_q  <= sign_d;
      wbit_q  <= wbit_d;
      col_q   <= col_d;
      en_q    <= en_d;
      last_q  <= last_d;
      load_q  <= load_d;
      first_q <= first_d;
      mag_q   <= mag_d;
    end
  end

  assign bus.w_ready    = ready;
  assign bus.sign       = sign_q;
  assign bus.w_bit      = wbit_q;
  assign bus.column_idx = col_q;
  assign bus.mac_en     = en_q && !bus.stall;
  assign bus.load_accum = load_q;
  assign bus.last_col   = last_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_weight_col_sequencer_16.sv
// Bench for weight_col_sequencer_16: directed + random stimulus
// checked each cycle against a column-queue reference model.
module tb_weight_col_sequencer_16;

  typedef logic [15:0][7:0] vec_t;

  logic clk = 1'b0;
  logic reset;

  weight_col_sequencer_16_if bus ();

  weight_col_sequencer_16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int en_cnt = 0;

  // model: 0 idle, 1 column beat, 2 drain beat
  int          m_kind;
  int          m_cols[$];
  int          m_mag[16];
  logic [15:0] m_sign, m_wbit;
  int          m_col;
  logic        m_load, m_first;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h",
               tag, $time, got, exp);
    end
  endtask

  task automatic m_reset();
    m_kind  = 0;
    m_cols.delete();
    m_sign  = '0;
    m_wbit  = '0;
    m_col   = 0;
    m_load  = 1'b0;
    m_first = 1'b0;
    for (int j = 0; j < 16; j++) m_mag[j] = 0;
  endtask

  task automatic m_beat();
    m_col = m_cols.pop_front();
    for (int j = 0; j < 16; j++)
      m_wbit[j] = ((m_mag[j] >> m_col) & 1) != 0;
  endtask

  task automatic m_load_vec(input vec_t w);
    for (int j = 0; j < 16; j++) begin
      int x;
      x = int'($signed(w[j]));
      m_sign[j] = (x < 0);
      m_mag[j]  = (x < 0) ? -x : x;
      if (m_mag[j] > 127) m_mag[j] = 127;
    end
    m_cols.delete();
    for (int c = 6; c >= 0; c--) begin
`ifdef ZERO_COL_SKIP_EN
      bit any;
      any = 1'b0;
      for (int j = 0; j < 16; j++)
        if (((m_mag[j] >> c) & 1) != 0) any = 1'b1;
      if (any) m_cols.push_back(c);
`else
      m_cols.push_back(c);
`endif
    end
    if (m_cols.size() == 0) m_cols.push_back(0);
  endtask

  task automatic step(input logic r, input logic s,
                      input logic v, input vec_t w);
    logic last, rdy, acc;
    reset       = r;
    bus.stall   = s;
    bus.w_valid = v;
    bus.w_in    = w;
    #1;
    last = (m_kind == 1) && (m_cols.size() == 0);
    rdy  = !r && !s && (m_kind != 1 || last);
    acc  = v && rdy;
    chk("w_ready", 32'(bus.w_ready), 32'(rdy));
    chk("mac_en", 32'(bus.mac_en),
        32'(m_kind != 0 && !s));
    chk("busy", 32'(bus.busy), 32'(m_kind != 0));
    chk("last_col", 32'(bus.last_col), 32'(last));
    chk("load_accum", 32'(bus.load_accum), 32'(m_load));
    chk("sign", 32'(bus.sign), 32'(m_sign));
    chk("w_bit", 32'(bus.w_bit), 32'(m_wbit));
    chk("column_idx", 32'(bus.column_idx), 32'(m_col));
    if (bus.mac_en) en_cnt++;
    @(posedge clk);
    if (r) begin
      m_reset();
    end else if (!s) begin
      m_load  = m_first;
      m_first = 1'b0;
      if (acc) begin
        m_load_vec(w);
        m_beat();
        m_kind  = 1;
        m_first = 1'b1;
      end else if (m_kind == 1 && !last) begin
        m_beat();
      end else if (m_kind == 1) begin
        m_kind = 2;
        m_wbit = '0;
        m_col  = 0;
      end else begin
        m_kind = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, '0);
  endtask

  function automatic vec_t rnd_vec();
    vec_t w;
    for (int j = 0; j < 16; j++) begin
      case ($urandom_range(0, 9))
        0:       w[j] = 8'h00;
        1:       w[j] = 8'h80;
        2:       w[j] = 8'hff;
        3, 4, 5: w[j] = 8'($urandom_range(0, 7));
        default: w[j] = 8'($urandom);
      endcase
    end
    return w;
  endfunction

  initial begin
    vec_t w;
    int exp_zero;
    reset       = 1'b1;
    bus.stall   = 1'b0;
    bus.w_valid = 1'b0;
    bus.w_in    = '0;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, '0);
    idle(2);

    // lane0 = 5
    w = '0;
    w[0] = 8'd5;
    step(1'b0, 1'b0, 1'b1, w);
    idle(9);

    // all lanes -1
    w = '1;
    step(1'b0, 1'b0, 1'b1, w);
    idle(9);

    // lane3 = -128
    w = '0;
    w[3] = 8'h80;
    step(1'b0, 1'b0, 1'b1, w);
    idle(10);

    // all-zero vector: count mac_en beats
    en_cnt = 0;
    step(1'b0, 1'b0, 1'b1, '0);
    idle(10);
`ifdef ZERO_COL_SKIP_EN
    exp_zero = 2;
`else
    exp_zero = 8;
`endif
    chk("zero_vec_en_cycles", 32'(en_cnt), 32'(exp_zero));

    // weight 1
    w = '0;
    w[5] = 8'd1;
    step(1'b0, 1'b0, 1'b1, w);
    idle(10);

    // back-to-back with w_valid held
    for (int i = 0; i < 30; i++) begin
      w = '0;
      w[i % 16] = (i % 2 != 0) ? 8'h80 : 8'h03;
      step(1'b0, 1'b0, 1'b1, w);
    end
    idle(10);

    // stall mid-vector, then reset mid-vector
    w = '0;
    w[3] = 8'h80;
    step(1'b0, 1'b0, 1'b1, w);
    idle(2);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, rnd_vec());
    idle(1);
    step(1'b1, 1'b0, 1'b1, rnd_vec());
    idle(2);
    w = '0;
    w[0] = 8'd5;
    step(1'b0, 1'b0, 1'b1, w);
    idle(10);

    // random
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) < 6,
           rnd_vec());
    end
    idle(10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
